beat_sequencer: RTL and testbench

Plays a stored beatmap in time with the song. Sits directly downstream of the beatmap note ROM: it walks the ROM address once per beat and reads each 4-bit lane word after the ROM's one-cycle registered read. Non-rest words go out over a valid/ready handshake to the note spawner/renderer. It also flags beats that are lost because the consumer stalled.

---
 rtl/beat_sequencer_pkg.sv | 22 ++
 rtl/beat_sequencer_if.sv | 23 ++
 rtl/beat_sequencer_timer.sv | 33 +++
 rtl/beat_sequencer.sv | 165 ++++++++++++++++
 tb/tb_beat_sequencer.sv | 346 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/beat_sequencer_pkg.sv
// Shared types and constants for the beatmap playback slice.
// Defines the sequencer state encoding and the lane/address widths.
package beatmap_pkg;

    localparam int LANE_W = 4;
    localparam int ADDR_W = 13;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_BEAT = 3'd1,
        FETCH     = 3'd2,
        CAPTURE   = 3'd3,
        OFFER     = 3'd4,
        DONE      = 3'd5
    } seq_state_t;

    // An all-zero lane word is a rest: nothing to spawn on that beat.
    function automatic logic is_rest(input logic [LANE_W-1:0] lanes);
        return lanes == {LANE_W{1'b0}};
    endfunction

endpackage

// File: rtl/beat_sequencer_if.sv
// Note handshake between the sequencer (master) and the note spawner/renderer (slave).
interface beat_sequencer_if #(
    parameter int ADDR_W = beatmap_pkg::ADDR_W
);
    logic                            note_valid;
    logic                            note_ready;
    logic [beatmap_pkg::LANE_W-1:0]  note_lanes;
    logic [ADDR_W-1:0]               note_index;

    modport master (
        output note_valid,
        output note_lanes,
        output note_index,
        input  note_ready
    );

    modport slave (
        input  note_valid,
        input  note_lanes,
        input  note_index,
        output note_ready
    );
endinterface

// File: rtl/beat_sequencer_timer.sv
// Free-running beat counter; tick marks the last clock of each beat.
// Freezes (holding its count) whenever enable is low.
module beat_timer #(
    parameter int CLKS_PER_BEAT = 12_500_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);
    localparam int              CNT_W = $clog2(CLKS_PER_BEAT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BEAT - 1);

    logic [CNT_W-1:0] count_r;

    assign tick = enable && (count_r == LAST);

    // Beat counter: wraps after the tick cycle, held while disabled
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count_r <= {CNT_W{1'b0}};
        end else if (enable) begin
            if (count_r == LAST) begin
                count_r <= {CNT_W{1'b0}};
            end else begin
                count_r <= count_r + 1'b1;
            end
        end else begin
            count_r <= count_r;
        end
    end
endmodule

// File: rtl/beat_sequencer.sv
// Walks the beatmap ROM one entry per beat and offers non-rest lane words
// to the note consumer; flags beats lost while the consumer stalls.
module beat_sequencer #(
    parameter int CLKS_PER_BEAT = 12_500_000,
    parameter int SONG_LEN      = 17,
    parameter int ADDR_W        = beatmap_pkg::ADDR_W
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic                            pause,
    output logic [ADDR_W-1:0]               rom_addr,
    input  logic [beatmap_pkg::LANE_W-1:0]  rom_data,
    beat_sequencer_if.master                note,
    output logic                            beat_tick,
    output logic                            playing,
    output logic                            done,
    output logic                            overrun
);
    import beatmap_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(SONG_LEN - 1);

    seq_state_t          state_r;
    seq_state_t          next_state_s;
    seq_state_t          adv_state_s;
    logic [ADDR_W-1:0]   index_r;
    logic [ADDR_W-1:0]   note_index_r;
    logic [LANE_W-1:0]   note_lanes_r;
    logic                note_valid_r;
    logic                pending_r;
    logic                overrun_r;
    logic                playing_r;
    logic                done_r;
    logic                tick_s;
    logic                timer_en_s;
    logic                start_acc_s;
    logic                fetch_go_s;
    logic                advance_s;

    assign timer_en_s = playing_r && !pause;

    beat_timer #(
        .CLKS_PER_BEAT (CLKS_PER_BEAT)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (start_acc_s),
        .enable (timer_en_s),
        .tick   (tick_s)
    );

    // Next-state logic and per-cycle control strobes
    always_comb begin
        next_state_s = state_r;
        start_acc_s  = 1'b0;
        fetch_go_s   = 1'b0;
        advance_s    = 1'b0;
        adv_state_s  = (index_r == LAST_IDX) ? DONE : WAIT_BEAT;
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    next_state_s = WAIT_BEAT;
                    start_acc_s  = 1'b1;
                end else begin
                    next_state_s = state_r;
                end
            end
            WAIT_BEAT: begin
                if (pending_r && !pause) begin
                    next_state_s = FETCH;
                    fetch_go_s   = 1'b1;
                end else begin
                    next_state_s = WAIT_BEAT;
                end
            end
            FETCH: begin
                next_state_s = CAPTURE;
            end
            CAPTURE: begin
                if (is_rest(rom_data)) begin
                    next_state_s = adv_state_s;
                    advance_s    = 1'b1;
                end else begin
                    next_state_s = OFFER;
                end
            end
            OFFER: begin
                if (note_valid_r && note.note_ready) begin
                    next_state_s = adv_state_s;
                    advance_s    = 1'b1;
                end else begin
                    next_state_s = OFFER;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State, index and note output registers; status flags decoded from next state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            index_r      <= {ADDR_W{1'b0}};
            note_lanes_r <= {LANE_W{1'b0}};
            note_index_r <= {ADDR_W{1'b0}};
            note_valid_r <= 1'b0;
            playing_r    <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            state_r      <= next_state_s;
            note_valid_r <= (next_state_s == OFFER);
            playing_r    <= (next_state_s != IDLE) && (next_state_s != DONE);
            done_r       <= (next_state_s == DONE);
            if (start_acc_s) begin
                index_r <= {ADDR_W{1'b0}};
            end else if (advance_s && (index_r != LAST_IDX)) begin
                index_r <= index_r + 1'b1;
            end else begin
                index_r <= index_r;
            end
            if (state_r == CAPTURE) begin
                note_lanes_r <= rom_data;
                note_index_r <= index_r;
            end else begin
                note_lanes_r <= note_lanes_r;
                note_index_r <= note_index_r;
            end
        end
    end

    // A tick that lands on an already pending beat is lost unless the pending one is being consumed now
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_r <= 1'b0;
            overrun_r <= 1'b0;
        end else if (start_acc_s) begin
            pending_r <= 1'b1;
            overrun_r <= 1'b0;
        end else if (tick_s && pending_r && !fetch_go_s) begin
            pending_r <= 1'b1;
            overrun_r <= 1'b1;
        end else if (tick_s) begin
            pending_r <= 1'b1;
            overrun_r <= overrun_r;
        end else if (fetch_go_s) begin
            pending_r <= 1'b0;
            overrun_r <= overrun_r;
        end else begin
            pending_r <= pending_r;
            overrun_r <= overrun_r;
        end
    end

    assign rom_addr        = index_r;
    assign note.note_valid = note_valid_r;
    assign note.note_lanes = note_lanes_r;
    assign note.note_index = note_index_r;
    assign beat_tick       = tick_s;
    assign playing         = playing_r;
    assign done            = done_r;
    assign overrun         = overrun_r;
endmodule

// File: tb/tb_beat_sequencer.sv
// Scoreboard bench for beat_sequencer: 8-clock beats, 4-entry song, 1-cycle ROM model.
module tb_beat_sequencer;
    localparam int CPB = 8;

    typedef struct packed {
        logic [3:0]  lanes;
        logic [12:0] index;
        int          cyc;
    } hs_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic        pause;
    logic [12:0] rom_addr;
    logic [3:0]  rom_data;
    logic        beat_tick;
    logic        playing;
    logic        done;
    logic        overrun;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    hs_t exp_hs[$];
    hs_t obs_hs[$];
    int  exp_tick[$];
    int  obs_tick[$];

    beat_sequencer_if #(.ADDR_W(13)) nif();

    beat_sequencer #(
        .CLKS_PER_BEAT (CPB),
        .SONG_LEN      (4),
        .ADDR_W        (13)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .pause     (pause),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .note      (nif),
        .beat_tick (beat_tick),
        .playing   (playing),
        .done      (done),
        .overrun   (overrun)
    );

    function automatic logic [3:0] rom_word(input logic [12:0] a);
        case (a)
            13'd0:   return 4'b1111;
            13'd1:   return 4'b0000;
            13'd2:   return 4'b0110;
            13'd3:   return 4'b1010;
            default: return 4'b0000;
        endcase
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rom_data <= rom_word(rom_addr);
    end

    // Monitor: log every completed handshake and every beat tick
    always @(negedge clk) begin
        hs_t h;
        if (nif.note_valid === 1'b1 && nif.note_ready === 1'b1) begin
            h.lanes = nif.note_lanes;
            h.index = nif.note_index;
            h.cyc   = cyc;
            obs_hs.push_back(h);
        end
        if (beat_tick === 1'b1) obs_tick.push_back(cyc);
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) cycle();
    endtask

    task automatic clear_logs();
        exp_hs.delete();
        obs_hs.delete();
        exp_tick.delete();
        obs_tick.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        pause = 1'b0;
        cycle();
        cycle();
        reset = 1'b0;
        clear_logs();
    endtask

    task automatic kick(output int t0);
        start = 1'b1;
        t0    = cyc;
        cycle();
        start = 1'b0;
    endtask

    // Reference timing: entry i is offered 4 cycles after its beat (beat 0 = start); shift delays beats >= 1
    task automatic push_model(input int t0, input int shift);
        hs_t e;
        for (int i = 0; i < 4; i++) begin
            if (rom_word(13'(i)) != 4'b0000) begin
                e.lanes = rom_word(13'(i));
                e.index = 13'(i);
                e.cyc   = t0 + CPB * i + 4 + ((i > 0) ? shift : 0);
                exp_hs.push_back(e);
            end
        end
        for (int k = 1; k < 4; k++) exp_tick.push_back(t0 + CPB * k + shift);
    endtask

    task automatic wait_done(output int tdone);
        tdone = -1;
        for (int k = 0; k < 400; k++) begin
            if (done === 1'b1) begin
                tdone = cyc;
                break;
            end
            cycle();
        end
        total++;
        if (tdone < 0) begin
            bad++;
            $display("FAIL done_timeout: done still %b after 400 cycles, want 1", done);
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({nif.note_valid, nif.note_lanes, nif.note_index, rom_addr, beat_tick, playing, done, overrun} !== 35'd0) begin
            bad++;
            $display("FAIL reset_outputs: got v=%b l=%b i=%0d a=%0d t=%b p=%b d=%b o=%b, want all 0",
                     nif.note_valid, nif.note_lanes, nif.note_index, rom_addr, beat_tick, playing, done, overrun);
        end
    endtask

    task automatic test_normal();
        int t0, td;
        do_reset();
        nif.note_ready = 1'b1;
        kick(t0);
        push_model(t0, 0);
        wait_done(td);
        total++;
        if (td !== t0 + 29) begin bad++; $display("FAIL normal_done_cycle: got %0d want %0d", td - t0, 29); end
        total++;
        if (overrun !== 1'b0) begin bad++; $display("FAIL normal_overrun: got %b want 0", overrun); end
        total++;
        if (obs_hs.size() != exp_hs.size()) begin bad++; $display("FAIL normal_note_count: got %0d want %0d", obs_hs.size(), exp_hs.size()); end
        for (int i = 0; i < exp_hs.size() && i < obs_hs.size(); i++) begin
            total++;
            if (obs_hs[i] !== exp_hs[i]) begin
                bad++;
                $display("FAIL normal_note%0d: got l=%b i=%0d c=%0d want l=%b i=%0d c=%0d", i, obs_hs[i].lanes, obs_hs[i].index,
                         obs_hs[i].cyc - t0, exp_hs[i].lanes, exp_hs[i].index, exp_hs[i].cyc - t0);
            end
        end
        total++;
        if (obs_tick.size() != exp_tick.size()) begin bad++; $display("FAIL normal_tick_count: got %0d want %0d", obs_tick.size(), exp_tick.size()); end
        for (int i = 0; i < exp_tick.size() && i < obs_tick.size(); i++) begin
            total++;
            if (obs_tick[i] !== exp_tick[i]) begin bad++; $display("FAIL normal_tick%0d: got %0d want %0d", i, obs_tick[i] - t0, exp_tick[i] - t0); end
        end
    endtask

    task automatic test_stall();
        int t0, td;
        hs_t e;
        do_reset();
        nif.note_ready = 1'b1;
        kick(t0);
        e.lanes = 4'b1111; e.index = 13'd0; e.cyc = t0 + 4;  exp_hs.push_back(e);
        e.lanes = 4'b0110; e.index = 13'd2; e.cyc = t0 + 40; exp_hs.push_back(e);
        e.lanes = 4'b1010; e.index = 13'd3; e.cyc = t0 + 44; exp_hs.push_back(e);
        for (int k = 1; k <= 5; k++) exp_tick.push_back(t0 + CPB * k);
        wait_until(t0 + 20);
        nif.note_ready = 1'b0;
        for (int c = 20; c < 40; c++) begin
            total++;
            if ({nif.note_valid, nif.note_lanes, nif.note_index, overrun} !== {1'b1, 4'b0110, 13'd2, (c >= 33)}) begin
                bad++;
                $display("FAIL stall_hold_c%0d: got v=%b l=%b i=%0d o=%b want v=1 l=0110 i=2 o=%b", c,
                         nif.note_valid, nif.note_lanes, nif.note_index, overrun, (c >= 33));
            end
            cycle();
        end
        nif.note_ready = 1'b1;
        wait_done(td);
        total++;
        if (td !== t0 + 45) begin bad++; $display("FAIL stall_done_cycle: got %0d want %0d", td - t0, 45); end
        total++;
        if (obs_hs.size() != exp_hs.size()) begin bad++; $display("FAIL stall_note_count: got %0d want %0d", obs_hs.size(), exp_hs.size()); end
        for (int i = 0; i < exp_hs.size() && i < obs_hs.size(); i++) begin
            total++;
            if (obs_hs[i] !== exp_hs[i]) begin
                bad++;
                $display("FAIL stall_note%0d: got l=%b i=%0d c=%0d want l=%b i=%0d c=%0d", i, obs_hs[i].lanes, obs_hs[i].index,
                         obs_hs[i].cyc - t0, exp_hs[i].lanes, exp_hs[i].index, exp_hs[i].cyc - t0);
            end
        end
        total++;
        if (obs_tick.size() != exp_tick.size()) begin bad++; $display("FAIL stall_tick_count: got %0d want %0d", obs_tick.size(), exp_tick.size()); end
    endtask

    task automatic test_restart();
        int t0, td;
        total++;
        if ({done, overrun} !== 2'b11) begin bad++; $display("FAIL restart_pre: got done=%b overrun=%b want 1 1", done, overrun); end
        clear_logs();
        kick(t0);
        push_model(t0, 0);
        total++;
        if ({playing, done, overrun, rom_addr} !== {1'b1, 1'b0, 1'b0, 13'd0}) begin
            bad++;
            $display("FAIL restart_state: got p=%b d=%b o=%b a=%0d want p=1 d=0 o=0 a=0", playing, done, overrun, rom_addr);
        end
        wait_until(t0 + 6);
        start = 1'b1;
        cycle();
        start = 1'b0;
        wait_done(td);
        total++;
        if (td !== t0 + 29) begin bad++; $display("FAIL restart_done_cycle: got %0d want %0d", td - t0, 29); end
        total++;
        if (obs_hs.size() != exp_hs.size()) begin bad++; $display("FAIL restart_note_count: got %0d want %0d", obs_hs.size(), exp_hs.size()); end
        for (int i = 0; i < exp_hs.size() && i < obs_hs.size(); i++) begin
            total++;
            if (obs_hs[i] !== exp_hs[i]) begin
                bad++;
                $display("FAIL restart_note%0d: got i=%0d c=%0d want i=%0d c=%0d", i, obs_hs[i].index, obs_hs[i].cyc - t0,
                         exp_hs[i].index, exp_hs[i].cyc - t0);
            end
        end
        for (int i = 0; i < exp_tick.size() && i < obs_tick.size(); i++) begin
            total++;
            if (obs_tick[i] !== exp_tick[i]) begin bad++; $display("FAIL restart_tick%0d: got %0d want %0d", i, obs_tick[i] - t0, exp_tick[i] - t0); end
        end
    endtask

    task automatic test_pause();
        int t0, td;
        do_reset();
        nif.note_ready = 1'b1;
        kick(t0);
        push_model(t0, 30);
        wait_until(t0 + 6);
        pause = 1'b1;
        for (int k = 0; k < 30; k++) begin
            total++;
            if ({playing, rom_addr} !== {1'b1, 13'd1}) begin
                bad++;
                $display("FAIL pause_hold_k%0d: got p=%b a=%0d want p=1 a=1", k, playing, rom_addr);
            end
            cycle();
        end
        pause = 1'b0;
        wait_done(td);
        total++;
        if (td !== t0 + 59) begin bad++; $display("FAIL pause_done_cycle: got %0d want %0d", td - t0, 59); end
        total++;
        if (obs_tick.size() != exp_tick.size()) begin bad++; $display("FAIL pause_tick_count: got %0d want %0d", obs_tick.size(), exp_tick.size()); end
        for (int i = 0; i < exp_tick.size() && i < obs_tick.size(); i++) begin
            total++;
            if (obs_tick[i] !== exp_tick[i]) begin bad++; $display("FAIL pause_tick%0d: got %0d want %0d", i, obs_tick[i] - t0, exp_tick[i] - t0); end
        end
        for (int i = 0; i < exp_hs.size() && i < obs_hs.size(); i++) begin
            total++;
            if (obs_hs[i] !== exp_hs[i]) begin
                bad++;
                $display("FAIL pause_note%0d: got i=%0d c=%0d want i=%0d c=%0d", i, obs_hs[i].index, obs_hs[i].cyc - t0,
                         exp_hs[i].index, exp_hs[i].cyc - t0);
            end
        end
    endtask

    task automatic test_reset_offer();
        int t0, td;
        do_reset();
        nif.note_ready = 1'b0;
        kick(t0);
        wait_until(t0 + 6);
        total++;
        if ({nif.note_valid, nif.note_lanes} !== {1'b1, 4'b1111}) begin
            bad++;
            $display("FAIL offer_pre: got v=%b l=%b want v=1 l=1111", nif.note_valid, nif.note_lanes);
        end
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        total++;
        if ({nif.note_valid, nif.note_lanes, nif.note_index, rom_addr, beat_tick, playing, done, overrun} !== 35'd0) begin
            bad++;
            $display("FAIL offer_reset: got v=%b l=%b i=%0d a=%0d t=%b p=%b d=%b o=%b, want all 0",
                     nif.note_valid, nif.note_lanes, nif.note_index, rom_addr, beat_tick, playing, done, overrun);
        end
        clear_logs();
        nif.note_ready = 1'b1;
        kick(t0);
        push_model(t0, 0);
        wait_done(td);
        total++;
        if (obs_hs.size() != exp_hs.size()) begin bad++; $display("FAIL replay_note_count: got %0d want %0d", obs_hs.size(), exp_hs.size()); end
        for (int i = 0; i < exp_hs.size() && i < obs_hs.size(); i++) begin
            total++;
            if (obs_hs[i] !== exp_hs[i]) begin
                bad++;
                $display("FAIL replay_note%0d: got l=%b i=%0d c=%0d want l=%b i=%0d c=%0d", i, obs_hs[i].lanes, obs_hs[i].index,
                         obs_hs[i].cyc - t0, exp_hs[i].lanes, exp_hs[i].index, exp_hs[i].cyc - t0);
            end
        end
    endtask

    initial begin
        reset          = 1'b1;
        start          = 1'b0;
        pause          = 1'b0;
        nif.note_ready = 1'b0;
        test_reset();
        test_normal();
        test_stall();
        test_restart();
        test_pause();
        test_reset_offer();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
